// File: rtl/axilite_regbank_write_pkg.sv
// axilite_pkg: AXI4-Lite response codes and the strobe-shift helper shared by the CSR write bank.
package axilite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    function automatic int strb_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction
endpackage

// File: rtl/axilite_regbank_write_if.sv
// axilite_regbank_write_if: AXI4-Lite write-channel bundle (AW, W, B) with master/slave views.
interface axilite_regbank_write_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 32
);
    logic [ADDR_SIZE-1:0]    awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axilite_regbank_write_hold_reg.sv
// axilite_hold_reg: one-entry valid/ready capture register, emptied by clear.
module axilite_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             clear,
    output logic             held,
    output logic [WIDTH-1:0] q
);
    assign ready = !held;

    // clear only fires while held, so it never races a capture
    always_ff @(posedge clk) begin
        if (!rst) held <= 1'b0;
        else if (clear) held <= 1'b0;
        else if (valid && ready) held <= 1'b1;
        if (valid && ready) q <= data;
    end
endmodule

// File: rtl/axilite_regbank_write.sv
// axilite_regbank_write: AXI4-Lite write slave for the CSR bank with decode, strobes and B backpressure.
// Defining AXIL_WR_PULSE_EN adds wr_pulse, one cycle high per register on each OKAY commit.
module axilite_regbank_write
    import axilite_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             ADDR_SIZE  = 32,
    parameter int                             NUM_REGS   = 4,
    parameter logic [ADDR_SIZE-1:0]           BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axilite_regbank_write_if.slave         bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs
`ifdef AXIL_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]            wr_pulse
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int SHIFT = strb_shift(DATA_WIDTH);

    logic                  aw_held, w_held, commit;
    logic [ADDR_SIZE-1:0]  aw_addr, off, idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [NUM_REGS-1:0]   hit, we;
    logic [1:0]            resp;

    axilite_hold_reg #(.WIDTH(ADDR_SIZE)) u_aw (
        .clk(clk), .rst(rst), .data(bus.awaddr), .valid(bus.awvalid), .ready(bus.awready),
        .clear(commit), .held(aw_held), .q(aw_addr)
    );

    axilite_hold_reg #(.WIDTH(DATA_WIDTH + NB)) u_w (
        .clk(clk), .rst(rst), .data({bus.wstrb, bus.wdata}), .valid(bus.wvalid), .ready(bus.wready),
        .clear(commit), .held(w_held), .q({w_strb, w_data})
    );

    assign commit = aw_held && w_held && (!bus.bvalid || bus.bready);
    // modular subtraction makes addresses below the base land far out of range
    assign off    = aw_addr - BASE_ADDR;
    assign idx    = off >> SHIFT;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) hit[i] = idx == ADDR_SIZE'(i);
    end

    assign we   = commit ? (hit & ~RO_MASK) : '0;
    assign resp = ~|hit ? RESP_DECERR : |(hit & RO_MASK) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (!rst) regs <= RESET_VAL;
        else
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < NB; k++)
                    if (we[i] && w_strb[k]) regs[i*DATA_WIDTH + k*8 +: 8] <= w_data[k*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.bvalid <= 1'b0;
            bus.bresp  <= RESP_OKAY;
        end else if (commit) begin
            bus.bvalid <= 1'b1;
            bus.bresp  <= resp;
        end else if (bus.bready) begin
            bus.bvalid <= 1'b0;
        end
    end

`ifdef AXIL_WR_PULSE_EN
    always_ff @(posedge clk) wr_pulse <= rst ? we : '0;
`endif
endmodule
